// File: rtl/matrix_multiply_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : matrix_multiply_host
// Description : Host-side sequencer for the pin-level 2x2 matrix multiplier
//               core. Loads eight elements (A then B, row-major) from a
//               valid/ready stream through mm_sel_in/mm_input_val, strobes
//               mm_execute, waits EXEC_WAIT cycles, then walks mm_sel_out
//               0..3 and returns the four results on a valid/ready stream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high reset
//   in_data      in   DATA_W  element value
//   in_valid     in   1       element present
//   in_ready     out  1       element accepted when in_valid & in_ready
//   out_data     out  RES_W   result value
//   out_valid    out  1       result present, held until accepted
//   out_ready    in   1       consumer accepts
//   busy         out  1       transaction in progress
//   done         out  1       one-cycle pulse after the 4th result handshake
//   mm_sel_in    out  3       element index to the core
//   mm_input_val out  DATA_W  element value to the core
//   mm_execute   out  1       execute strobe to the core
//   mm_sel_out   out  2       result index to the core
//   mm_result    in   RES_W   result from the core
// ============================================================================
module matrix_multiply_host #(
    parameter int DATA_W    = 8,
    parameter int RES_W     = 17,
    parameter int EXEC_WAIT = 4     // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [RES_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        mm_sel_in,
    output logic [DATA_W-1:0] mm_input_val,
    output logic              mm_execute,
    output logic [1:0]        mm_sel_out,
    input  logic [RES_W-1:0]  mm_result
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_RSET   = 3'd5;
    localparam logic [2:0] S_RCAP   = 3'd6;
    localparam logic [2:0] S_SEND   = 3'd7;

    // WAIT is entered with the counter at zero, so the last WAIT cycle is the
    // one where the counter reads EXEC_WAIT-1.
    localparam logic [3:0] C_WAIT_LAST = 4'(EXEC_WAIT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;

    logic [2:0]        r_idx;
    logic [2:0]        w_idx_next;
    logic [1:0]        r_k;
    logic [1:0]        w_k_next;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        w_wait_cnt_next;

    logic [2:0]        w_sel_in_next;
    logic [DATA_W-1:0] w_input_val_next;
    logic              w_execute_next;
    logic [1:0]        w_sel_out_next;
    logic [RES_W-1:0]  w_out_data_next;
    logic              w_out_valid_next;
    logic              w_done_next;

    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_wait_last;

    // in_ready/busy are pure state decodes; everything else is registered.
    assign in_ready    = (r_state == S_LOAD);
    assign busy        = !((r_state == S_IDLE) ||
                           ((r_state == S_LOAD) && (r_idx == 3'd0)));

    // Handshakes are qualified by state so stray in_valid/out_ready are inert.
    assign w_in_hs     = (r_state == S_LOAD) && in_valid;
    assign w_out_hs    = (r_state == S_SEND) && out_ready;
    assign w_wait_last = (r_wait_cnt == C_WAIT_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = S_LOAD;
            S_LOAD:   if (w_in_hs && (r_idx == 3'd7)) w_state_next = S_SETTLE;
            S_SETTLE: w_state_next = S_EXEC;
            S_EXEC:   w_state_next = S_WAIT;
            S_WAIT:   if (w_wait_last) w_state_next = S_RSET;
            S_RSET:   w_state_next = S_RCAP;
            S_RCAP:   w_state_next = S_SEND;
            S_SEND: begin
                if (w_out_hs) begin
                    w_state_next = (r_k == 2'd3) ? S_LOAD : S_RSET;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / datapath next-value logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_idx_next       = r_idx;
        w_k_next         = r_k;
        w_wait_cnt_next  = r_wait_cnt;
        w_sel_in_next    = mm_sel_in;
        w_input_val_next = mm_input_val;
        w_execute_next   = 1'b0;
        w_sel_out_next   = mm_sel_out;
        w_out_data_next  = out_data;
        w_out_valid_next = out_valid;
        w_done_next      = 1'b0;

        case (r_state)
            S_LOAD: begin
                if (w_in_hs) begin
                    w_sel_in_next    = r_idx;
                    w_input_val_next = in_data;
                    w_idx_next       = (r_idx == 3'd7) ? 3'd0 : r_idx + 3'd1;
                end
            end
            S_SETTLE: begin
                // Registered strobe: raised here so it is high during EXEC only.
                w_execute_next = 1'b1;
            end
            S_EXEC: begin
                w_wait_cnt_next = 4'd0;
            end
            S_WAIT: begin
                w_wait_cnt_next = r_wait_cnt + 4'd1;
                if (w_wait_last) begin
                    w_sel_out_next = r_k;
                end
            end
            S_RCAP: begin
                // RSET gave the core a full cycle to settle after mm_sel_out moved.
                w_out_data_next  = mm_result;
                w_out_valid_next = 1'b1;
            end
            S_SEND: begin
                if (w_out_hs) begin
                    w_out_valid_next = 1'b0;
                    if (r_k == 2'd3) begin
                        w_k_next    = 2'd0;
                        w_done_next = 1'b1;
                    end else begin
                        w_k_next       = r_k + 2'd1;
                        w_sel_out_next = r_k + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath / registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= 3'd0;
            r_k          <= 2'd0;
            r_wait_cnt   <= 4'd0;
            mm_sel_in    <= 3'd0;
            mm_input_val <= '0;
            mm_execute   <= 1'b0;
            mm_sel_out   <= 2'd0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_idx        <= w_idx_next;
            r_k          <= w_k_next;
            r_wait_cnt   <= w_wait_cnt_next;
            mm_sel_in    <= w_sel_in_next;
            mm_input_val <= w_input_val_next;
            mm_execute   <= w_execute_next;
            mm_sel_out   <= w_sel_out_next;
            out_data     <= w_out_data_next;
            out_valid    <= w_out_valid_next;
            done         <= w_done_next;
        end
    end

endmodule
`default_nettype wire
